// File: rtl/lb_pkg.sv
// lb_pkg: shared widths, state encoding and command layout for the region dispatcher.
package lb_pkg;
  localparam int DEFAULT_OPERATOR_ID_WIDTH = 16;
  localparam int DEFAULT_N_REGIONS = 4;
  localparam logic [DEFAULT_OPERATOR_ID_WIDTH-1:0] EMPTY_OP = '1;
  typedef enum logic [2:0] {IDLE, LOOKUP, DISPATCH, RECONF_REQ, RECONF_WAIT} state_t;
  typedef struct packed {
    logic [DEFAULT_OPERATOR_ID_WIDTH-1:0] region;
    logic [DEFAULT_OPERATOR_ID_WIDTH-1:0] op;
  } ctrl_t;
endpackage

// File: rtl/region_select.sv
// region_select: hit, empty-region and round-robin victim search over the region table.
module region_select import lb_pkg::*; #(
  parameter int W = DEFAULT_OPERATOR_ID_WIDTH,
  parameter int N = DEFAULT_N_REGIONS,
  localparam int IW = $clog2(N)
) (
  input  logic [N*W-1:0] stats,
  input  logic [N-1:0]   busy,
  input  logic [W-1:0]   op,
  input  logic [IW-1:0]  rr_ptr,
  output logic           hit,
  output logic [IW-1:0]  hit_idx,
  output logic           match_any,
  output logic           victim_ok,
  output logic [IW-1:0]  victim_idx
);
  logic          empty_ok;
  logic [IW-1:0] empty_idx, rr_idx;
  // Descending scans so the lowest qualifying index (or nearest to rr_ptr) wins.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    match_any = 1'b0;
    empty_ok = 1'b0;
    empty_idx = '0;
    victim_ok = 1'b0;
    rr_idx = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (stats[i*W +: W] == op) begin
        match_any = 1'b1;
        if (!busy[i]) begin
          hit = 1'b1;
          hit_idx = IW'(i);
        end
      end
      if (stats[i*W +: W] == '1 && !busy[i]) begin
        empty_ok = 1'b1;
        empty_idx = IW'(i);
      end
      if (!busy[rr_ptr + IW'(i)]) begin
        victim_ok = 1'b1;
        rr_idx = rr_ptr + IW'(i);
      end
    end
  end
  assign victim_idx = empty_ok ? empty_idx : rr_idx;
endmodule

// File: rtl/region_dispatcher.sv
// region_dispatcher: routes each request to a region holding its operator, reconfiguring a victim on a miss.
module region_dispatcher import lb_pkg::*; #(
  parameter int OPERATOR_ID_WIDTH = DEFAULT_OPERATOR_ID_WIDTH,
  parameter int N_REGIONS = DEFAULT_N_REGIONS,
  parameter int PR_TIMEOUT = 1024
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [OPERATOR_ID_WIDTH-1:0]   req_op,
  input  logic [N_REGIONS*OPERATOR_ID_WIDTH-1:0] region_stats_in,
  input  logic [N_REGIONS-1:0]           region_busy,
  output logic                           lb_valid,
  input  logic                           lb_ready,
  output logic [2*OPERATOR_ID_WIDTH-1:0] lb_ctrl,
  output logic                           pr_valid,
  input  logic                           pr_ready,
  output logic [2*OPERATOR_ID_WIDTH-1:0] pr_ctrl,
  input  logic                           pr_done,
  output logic                           pr_error,
  output logic [15:0]                    pr_count
);
  localparam int IW = $clog2(N_REGIONS);
  localparam int CW = $clog2(PR_TIMEOUT) + 1;
  state_t state, next;
  logic [OPERATOR_ID_WIDTH-1:0] op_q;
  logic [IW-1:0] idx_q, rr_ptr, hit_idx, victim_idx;
  logic [CW-1:0] cnt;
  logic hit, match_any, victim_ok, timeout;
  ctrl_t cmd;
  region_select #(.W(OPERATOR_ID_WIDTH), .N(N_REGIONS)) u_sel (
    .stats(region_stats_in), .busy(region_busy), .op(op_q), .rr_ptr(rr_ptr),
    .hit(hit), .hit_idx(hit_idx), .match_any(match_any),
    .victim_ok(victim_ok), .victim_idx(victim_idx)
  );
  assign timeout = cnt == CW'(PR_TIMEOUT - 1);
  always_ff @(posedge aclk) state <= areset ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE:        next = (req_valid && req_ready) ? LOOKUP : IDLE;
      LOOKUP:      next = hit ? DISPATCH : (!match_any && victim_ok) ? RECONF_REQ : LOOKUP;
      DISPATCH:    next = lb_ready ? IDLE : DISPATCH;
      RECONF_REQ:  next = pr_ready ? RECONF_WAIT : RECONF_REQ;
      RECONF_WAIT: next = pr_done ? DISPATCH : timeout ? IDLE : RECONF_WAIT;
      default:     next = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      req_ready <= 1'b0;
      op_q <= '0;
      idx_q <= '0;
      rr_ptr <= '0;
      cnt <= '0;
      pr_error <= 1'b0;
      pr_count <= '0;
    end else begin
      req_ready <= next == IDLE;
      if (state == IDLE && req_valid && req_ready) op_q <= req_op;
      if (state == LOOKUP) idx_q <= hit ? hit_idx : victim_idx;
      if (state == RECONF_REQ && pr_ready) cnt <= '0;
      if (state == RECONF_WAIT && pr_done) begin
        pr_count <= pr_count + 16'(pr_count != 16'hFFFF);
        rr_ptr <= idx_q + IW'(1);
      end else if (state == RECONF_WAIT) begin
        cnt <= cnt + CW'(1);
        if (timeout) pr_error <= 1'b1;
      end
    end
  end
  always_comb begin
    cmd = '{region: OPERATOR_ID_WIDTH'(idx_q), op: op_q};
    lb_valid = state == DISPATCH;
    pr_valid = state == RECONF_REQ;
    lb_ctrl = lb_valid ? cmd : '0;
    pr_ctrl = pr_valid ? cmd : '0;
  end
endmodule
